// File: rtl/game_pkg.sv
// Shared types and default timing for the cat-vs-dog throw game.
package game_pkg;
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    TURN_WAIT = 3'd1,
    CHARGE    = 3'd2,
    FLIGHT    = 3'd3,
    GAP       = 3'd4
  } ctrl_state_t;

  localparam logic PLAYER_CAT = 1'b0;
  localparam logic PLAYER_DOG = 1'b1;

  localparam int DEF_CHARGE_DIV     = 260000;
  localparam int DEF_POWER_MAX      = 255;
  localparam int DEF_TURN_GAP       = 32500000;
  localparam int DEF_FLIGHT_TIMEOUT = 16777215;
  localparam int TIMER_W            = 25;
endpackage

// File: rtl/power_charger.sv
// Prescaled, saturating 8-bit throw power counter.
module power_charger #(
  parameter int CHARGE_DIV = 260000,
  parameter int POWER_MAX  = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_clr,
  input  logic       i_en,
  input  logic       i_hold,
  output logic [7:0] o_power
);
  localparam int PW = (CHARGE_DIV > 1) ? $clog2(CHARGE_DIV) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(CHARGE_DIV - 1);
  localparam logic [7:0]    PMAX    = 8'(POWER_MAX);

  logic [PW-1:0] r_ps;
  logic [7:0]    r_power;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ps    <= '0;
      r_power <= '0;
    end else if (i_clr) begin
      r_ps    <= '0;
      r_power <= '0;
    end else if (i_en && !i_hold) begin
      if (r_ps == PS_LAST) begin
        r_ps <= '0;
        // saturate rather than wrap
        if (r_power < PMAX) r_power <= r_power + 8'd1;
      end else begin
        r_ps <= r_ps + 1'b1;
      end
    end
  end

  assign o_power = r_power;
endmodule

// File: rtl/turn_ctrl.sv
// Turn sequencer: grants the throw resource to one player, charges power while fire is held.
module turn_ctrl
  import game_pkg::*;
#(
  parameter int CHARGE_DIV     = DEF_CHARGE_DIV,
  parameter int POWER_MAX      = DEF_POWER_MAX,
  parameter int TURN_GAP       = DEF_TURN_GAP,
  parameter int FLIGHT_TIMEOUT = DEF_FLIGHT_TIMEOUT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_start,
  input  logic       i_game_over,
  input  logic       i_fire_btn,
  input  logic       i_throw_complete_cat,
  input  logic       i_throw_complete_dog,
  output logic       o_turn_active_cat,
  output logic       o_turn_active_dog,
  output logic       o_throw_command,
  output logic [7:0] o_throw_power,
  output logic       o_current_player,
  output logic [2:0] o_ctrl_state
);
  localparam logic [TIMER_W-1:0] GAP_LAST = TIMER_W'(TURN_GAP - 1);
  localparam logic [TIMER_W-1:0] FT_LAST  = TIMER_W'(FLIGHT_TIMEOUT);

  ctrl_state_t        r_state;
  logic               r_player;
  logic               r_armed;
  logic [TIMER_W-1:0] r_timer;

  logic w_press, w_gap_done, w_done, w_in_turn;
  logic w_clr, w_en, w_hold;

  assign w_press    = (r_state == TURN_WAIT) && i_fire_btn && r_armed;
  assign w_gap_done = (r_state == GAP) && (r_timer == GAP_LAST);
  assign w_done     = (r_player == PLAYER_CAT) ? i_throw_complete_cat : i_throw_complete_dog;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_player <= PLAYER_CAT;
      r_armed  <= 1'b0;
      r_timer  <= '0;
    end else if (i_game_over) begin
      r_state <= IDLE;
      r_armed <= 1'b0;
      r_timer <= '0;
    end else begin
      case (r_state)
        IDLE: if (i_start) begin
          r_state  <= TURN_WAIT;
          r_player <= PLAYER_CAT;
        end
        TURN_WAIT: begin
          // a button already held on entry must be released before it can fire
          if (w_press) begin
            r_state <= CHARGE;
            r_armed <= 1'b0;
          end else if (!i_fire_btn) begin
            r_armed <= 1'b1;
          end
        end
        CHARGE: if (!i_fire_btn) begin
          r_state <= FLIGHT;
          r_timer <= '0;
        end
        FLIGHT: begin
          if (w_done || r_timer == FT_LAST) begin
            r_state <= GAP;
            r_timer <= '0;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        GAP: begin
          if (w_gap_done) begin
            r_state  <= TURN_WAIT;
            r_player <= ~r_player;
            r_armed  <= 1'b0;
            r_timer  <= '0;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign w_clr  = i_game_over || w_press || w_gap_done;
  assign w_en   = (r_state == CHARGE);
  assign w_hold = (r_state != CHARGE);

  power_charger #(.CHARGE_DIV(CHARGE_DIV), .POWER_MAX(POWER_MAX)) u_charger (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (w_clr),
    .i_en    (w_en),
    .i_hold  (w_hold),
    .o_power (o_throw_power)
  );

  assign w_in_turn         = (r_state == TURN_WAIT) || (r_state == CHARGE) || (r_state == FLIGHT);
  assign o_turn_active_cat = w_in_turn && (r_player == PLAYER_CAT);
  assign o_turn_active_dog = w_in_turn && (r_player == PLAYER_DOG);
  assign o_throw_command   = (r_state == CHARGE);
  assign o_current_player  = r_player;
  assign o_ctrl_state      = r_state;

  a_one_turn: assert property (@(posedge clk) disable iff (rst)
    !(o_turn_active_cat && o_turn_active_dog));
endmodule

// File: tb/tb_turn_ctrl.sv
// Directed scoreboard bench for turn_ctrl with short timing parameters.
module tb_turn_ctrl;
  localparam int S_STATE = 0, S_TAC = 1, S_TAD = 2, S_CMD = 3, S_PWR = 4, S_CP = 5;

  typedef struct {
    string       tag;
    int          sig;
    logic [31:0] val;
  } exp_t;

  logic clk = 1'b0, rst = 1'b1;
  logic start = 0, game_over = 0, fire = 0, tcc = 0, tcd = 0;
  logic tac, tad, cmd, cp;
  logic [7:0] pwr;
  logic [2:0] st;

  exp_t sb[$];
  int n_tot = 0, n_pass = 0;
  logic rst_win = 0, spur = 0;

  turn_ctrl #(.CHARGE_DIV(4), .POWER_MAX(255), .TURN_GAP(8), .FLIGHT_TIMEOUT(100)) dut (
    .clk(clk), .rst(rst), .i_start(start), .i_game_over(game_over), .i_fire_btn(fire),
    .i_throw_complete_cat(tcc), .i_throw_complete_dog(tcd),
    .o_turn_active_cat(tac), .o_turn_active_dog(tad), .o_throw_command(cmd),
    .o_throw_power(pwr), .o_current_player(cp), .o_ctrl_state(st));

  always #5 clk = ~clk;

  always @(negedge clk) if (!rst && tac && tad) begin
    n_tot++;
    $error("FAIL both_active: cat=%0b dog=%0b expected not both", tac, tad);
  end

  always @(cmd) if (rst_win && cmd) spur = 1'b1;

  function automatic logic [31:0] obs(int sig);
    case (sig)
      S_STATE: return {29'd0, st};
      S_TAC:   return {31'd0, tac};
      S_TAD:   return {31'd0, tad};
      S_CMD:   return {31'd0, cmd};
      S_PWR:   return {24'd0, pwr};
      default: return {31'd0, cp};
    endcase
  endfunction

  task automatic chk(string tag, logic [31:0] o, logic [31:0] e);
    n_tot++;
    assert (o === e) n_pass++;
    else $error("FAIL %s: got %0d expected %0d", tag, o, e);
  endtask

  task automatic expect_v(string tag, int sig, int val);
    exp_t x;
    x.tag = tag; x.sig = sig; x.val = 32'(val);
    sb.push_back(x);
  endtask

  task automatic verify();
    exp_t x;
    while (sb.size() > 0) begin
      x = sb.pop_front();
      chk(x.tag, obs(x.sig), x.val);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic ticks(int n);
    repeat (n) tick();
  endtask

  int cnt;
  logic [7:0] prev;
  logic wrapped;

  initial begin
    // 1: reset state, then start
    #12;
    expect_v("rst_state", S_STATE, 0); expect_v("rst_tac", S_TAC, 0);
    expect_v("rst_tad", S_TAD, 0); expect_v("rst_cmd", S_CMD, 0);
    expect_v("rst_pwr", S_PWR, 0); expect_v("rst_cp", S_CP, 0);
    verify();
    @(negedge clk); rst = 0;
    tick(); start = 1; tick(); start = 0;
    expect_v("start_state", S_STATE, 1); expect_v("start_tac", S_TAC, 1);
    expect_v("start_tad", S_TAD, 0); expect_v("start_cp", S_CP, 0);
    expect_v("start_cmd", S_CMD, 0);
    verify();

    // 2: 41-cycle charge -> power 10, complete -> gap -> dog
    tick(); fire = 1; cnt = 0;
    repeat (41) begin tick(); if (cmd) cnt++; end
    fire = 0; tick();
    chk("cmd_cycles", 32'(cnt), 32'd41);
    expect_v("flight_state", S_STATE, 3); expect_v("flight_cmd", S_CMD, 0);
    expect_v("flight_pwr", S_PWR, 10);
    verify();
    ticks(5);
    expect_v("pwr_frozen", S_PWR, 10); verify();
    tcc = 1; tick(); tcc = 0;
    expect_v("gap_state", S_STATE, 4); expect_v("gap_tac", S_TAC, 0);
    expect_v("gap_pwr", S_PWR, 10);
    verify();
    ticks(7);
    expect_v("gap7_state", S_STATE, 4); verify();
    tick();
    expect_v("dog_state", S_STATE, 1); expect_v("dog_tad", S_TAD, 1);
    expect_v("dog_tac", S_TAC, 0); expect_v("dog_cp", S_CP, 1);
    expect_v("dog_pwr", S_PWR, 0);
    verify();

    // start outside IDLE is ignored
    start = 1; tick(); start = 0;
    expect_v("start_ign_state", S_STATE, 1); expect_v("start_ign_cp", S_CP, 1); verify();

    // 3: long hold saturates at 255 without wrapping
    tick(); fire = 1; tick(); prev = pwr; wrapped = 0;
    repeat (2000) begin tick(); if (pwr < prev) wrapped = 1; prev = pwr; end
    chk("no_wrap", {31'd0, wrapped}, 32'd0);
    expect_v("sat_pwr", S_PWR, 255); expect_v("sat_state", S_STATE, 2); verify();
    fire = 0; tick();
    expect_v("sat_flight_pwr", S_PWR, 255); verify();
    tcd = 1; tick(); tcd = 0;
    expect_v("dog_gap", S_STATE, 4); verify();

    // 4: fire held across the turn switch
    ticks(3); fire = 1; ticks(5);
    expect_v("held_cat_state", S_STATE, 1); expect_v("held_cp", S_CP, 0);
    verify();
    ticks(5);
    expect_v("held_no_charge", S_STATE, 1); expect_v("held_cmd", S_CMD, 0); verify();
    fire = 0; tick(); fire = 1; tick();
    expect_v("repress_charge", S_STATE, 2); verify();
    ticks(2); fire = 0; tick();
    expect_v("cat_flight", S_STATE, 3); verify();
    cnt = 0;
    tcd = 1; tick(); tcd = 0; cnt++;
    expect_v("ignore_dog_state", S_STATE, 3); expect_v("ignore_dog_tac", S_TAC, 1); verify();

    // 5: flight timeout forces gap after FLIGHT_TIMEOUT+1 cycles
    while (st == 3'd3 && cnt < 150) begin tick(); cnt++; end
    chk("timeout_cycles", 32'(cnt), 32'd101);
    expect_v("timeout_state", S_STATE, 4); verify();
    ticks(8);
    expect_v("timeout_toggle_cp", S_CP, 1); expect_v("timeout_tad", S_TAD, 1); verify();

    // 6: game_over during charge, then async reset mid-flight
    tick(); fire = 1; ticks(3);
    expect_v("go_pre_state", S_STATE, 2); verify();
    game_over = 1; tick(); game_over = 0; fire = 0;
    expect_v("go_state", S_STATE, 0); expect_v("go_cmd", S_CMD, 0);
    expect_v("go_tac", S_TAC, 0); expect_v("go_tad", S_TAD, 0);
    expect_v("go_pwr", S_PWR, 0); expect_v("go_cp_hold", S_CP, 1);
    verify();
    start = 1; tick(); start = 0;
    expect_v("restart_cp", S_CP, 0); verify();
    tick(); fire = 1; ticks(6); fire = 0; tick();
    expect_v("pre_rst_flight", S_STATE, 3); verify();
    #2; rst_win = 1; rst = 1; #1;
    expect_v("arst_state", S_STATE, 0); expect_v("arst_tac", S_TAC, 0);
    expect_v("arst_cmd", S_CMD, 0); expect_v("arst_pwr", S_PWR, 0);
    verify();
    @(negedge clk); rst = 0; ticks(4);
    rst_win = 0;
    chk("no_spurious_cmd", {31'd0, spur}, 32'd0);
    expect_v("post_rst_state", S_STATE, 0); verify();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run did not complete, got timeout expected finish");
    $fatal(1);
  end
endmodule
